// File: rtl/gift_key_sched.sv
// GIFT-128 round-key sequencer: one shared key-update unit, one 64-bit round key per handshake.
// Optional GIFT_KEY_SCHED_RC_EN adds the 6-bit round-constant LFSR output rc.
module gift_key_sched #(
    parameter int MAX_ROUNDS = 40,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [IDX_W-1:0] nrounds,
    input  logic             abort,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [63:0]      rk,
    output logic [IDX_W-1:0] rk_idx,
`ifdef GIFT_KEY_SCHED_RC_EN
    output logic [5:0]       rc,
`endif
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    state_t            state, state_nxt;
    logic [3:0][31:0]  k;          // k[3]=K3 ... k[0]=K0
    logic [IDX_W-1:0]  n_q, idx_q;
    logic [IDX_W-1:0]  n_ld;
    logic              accept, hs, last;

    function automatic logic [31:0] ku(input logic [31:0] x);
        return ((x >> 12) & 32'h0000_000F) | ((x << 4)  & 32'h0000_FFF0) |
               ((x >> 2)  & 32'h3FFF_0000) | ((x << 14) & 32'hC000_0000);
    endfunction

    assign n_ld   = (nrounds > IDX_W'(MAX_ROUNDS)) ? IDX_W'(MAX_ROUNDS) : nrounds;
    // abort outranks start in IDLE, so the start is dropped entirely
    assign accept = (state == IDLE) && start && !abort;
    assign hs     = (state == EMIT) && rk_ready;
    assign last   = (idx_q == n_q - 1'b1);

    assign busy     = (state == EMIT);
    assign rk_valid = (state == EMIT);
    assign done     = (state == FIN);
    assign rk       = {k[2], k[0]};
    assign rk_idx   = idx_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (n_ld == '0) ? FIN : EMIT;
            EMIT: begin
                if (abort)          state_nxt = IDLE;
                else if (hs && last) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            k     <= '0;
            n_q   <= '0;
            idx_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                k     <= key;
                n_q   <= n_ld;
                idx_q <= '0;
            end else if (hs && !abort) begin
                // a key consumed under abort is not advanced; the schedule is dead anyway
                k <= {ku(k[0]), k[3], k[2], k[1]};
                if (!last) idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef GIFT_KEY_SCHED_RC_EN
    logic [5:0] rc_q;

    // rc presents the step ahead of the register so round 0 reads 0x01 after a zero load
    assign rc = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                rc_q <= '0;
        else if (accept)          rc_q <= '0;
        else if (hs && !abort)    rc_q <= rc;
    end
`endif

endmodule

// File: tb/tb_gift_key_sched.sv
// Directed self-checking bench for gift_key_sched (round-key stream, backpressure, abort, reset).
module tb_gift_key_sched;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start, abort, rk_ready;
    logic [127:0]     key;
    logic [IDX_W-1:0] nrounds;
    logic             busy, rk_valid, done;
    logic [63:0]      rk;
    logic [IDX_W-1:0] rk_idx;
`ifdef GIFT_KEY_SCHED_RC_EN
    logic [5:0]       rc;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    gift_key_sched #(.MAX_ROUNDS(40), .IDX_W(IDX_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .key(key), .nrounds(nrounds),
        .abort(abort), .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk(rk), .rk_idx(rk_idx),
`ifdef GIFT_KEY_SCHED_RC_EN
        .rc(rc),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [127:0] k, input logic [IDX_W-1:0] n);
        key = k; nrounds = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 0; abort = 0; rk_ready = 0; key = '0; nrounds = '0;
        #23 rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, busy); end
            n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, rk_valid); end
            n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done cyc=%0d got=%b exp=0", c, done); end
            n_asserts++; if (rk !== 64'h0) begin n_fail++; $display("FAIL reset_rk cyc=%0d got=%h exp=0", c, rk); end
        end
    endtask

    task automatic test_single();
        rk_ready = 1'b1;
        kick(128'h00000000_00000000_00000000_00001234, 6'd1);
        n_asserts++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", rk_valid); end
        n_asserts++; if (rk !== 64'h00000000_00001234) begin n_fail++; $display("FAIL single_rk got=%h exp=0000000000001234", rk); end
        n_asserts++; if (rk_idx !== 6'd0) begin n_fail++; $display("FAIL single_idx got=%0d exp=0", rk_idx); end
        n_asserts++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        step();
        n_asserts++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done got=%b exp=1", done); end
        n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_off got=%b exp=0", rk_valid); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fin got=%b exp=0", busy); end
        step();
        n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_once got=%b exp=0", done); end
    endtask

    task automatic test_chain();
        logic [63:0] exp_rk [5];
        logic [5:0]  exp_rc [3];
        exp_rk[0] = 64'h00000000_00001234;
        exp_rk[1] = 64'h00000000_00000000;
        exp_rk[2] = 64'h00002341_00000000;
        exp_rk[3] = 64'h00000000_00000000;
        exp_rk[4] = 64'h00000000_00002341;
        exp_rc[0] = 6'h01; exp_rc[1] = 6'h03; exp_rc[2] = 6'h07;
        rk_ready = 1'b1;
        kick(128'h00000000_00000000_00000000_00001234, 6'd5);
        for (int i = 0; i < 5; i++) begin
            n_asserts++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL chain_valid r=%0d got=%b exp=1", i, rk_valid); end
            n_asserts++; if (rk !== exp_rk[i]) begin n_fail++; $display("FAIL chain_rk r=%0d got=%h exp=%h", i, rk, exp_rk[i]); end
            n_asserts++; if (rk_idx !== IDX_W'(i)) begin n_fail++; $display("FAIL chain_idx r=%0d got=%0d exp=%0d", i, rk_idx, i); end
`ifdef GIFT_KEY_SCHED_RC_EN
            if (i < 3) begin
                n_asserts++; if (rc !== exp_rc[i]) begin n_fail++; $display("FAIL chain_rc r=%0d got=%h exp=%h", i, rc, exp_rc[i]); end
            end
`endif
            step();
        end
        n_asserts++; if (done !== 1'b1) begin n_fail++; $display("FAIL chain_done got=%b exp=1", done); end
        step();
        // ku(0x00010000) = 0x40000000 surfaces in K0 on the fifth key
        kick(128'h00000000_00000000_00000000_00010000, 6'd5);
        for (int i = 0; i < 4; i++) step();
        n_asserts++; if (rk[31:0] !== 32'h40000000) begin n_fail++; $display("FAIL chain_ku got=%h exp=40000000", rk[31:0]); end
        step(); step();
    endtask

    task automatic test_backpressure();
        logic [39:0]      pat;
        logic [63:0]      exp_rk [3];
        logic [63:0]      prev_rk;
        logic [IDX_W-1:0] prev_idx;
        logic             prev_stall, rdy;
        int               hs, dn;
        pat = 40'b0000000000000000000000000_10011000101100;
        exp_rk[0] = 64'h22222222_00000000;
        exp_rk[1] = 64'h33333333_11111111;
        exp_rk[2] = 64'h00000000_22222222;
        rk_ready = 1'b0;
        kick(128'h33333333_22222222_11111111_00000000, 6'd3);
        hs = 0; dn = 0; prev_stall = 1'b0; prev_rk = '0; prev_idx = '0;
        for (int c = 0; c < 40; c++) begin
            if (rk_valid && prev_stall) begin
                n_asserts++; if (rk !== prev_rk) begin n_fail++; $display("FAIL bp_rk_stable cyc=%0d got=%h exp=%h", c, rk, prev_rk); end
                n_asserts++; if (rk_idx !== prev_idx) begin n_fail++; $display("FAIL bp_idx_stable cyc=%0d got=%0d exp=%0d", c, rk_idx, prev_idx); end
            end
            if (done) dn++;
            rdy = pat[c];
            rk_ready = rdy;
            if (rk_valid && rdy) begin
                if (hs < 3) begin
                    n_asserts++; if (rk_idx !== IDX_W'(hs)) begin n_fail++; $display("FAIL bp_idx hs=%0d got=%0d exp=%0d", hs, rk_idx, hs); end
                    n_asserts++; if (rk !== exp_rk[hs]) begin n_fail++; $display("FAIL bp_rk hs=%0d got=%h exp=%h", hs, rk, exp_rk[hs]); end
                end
                hs++;
            end
            prev_stall = rk_valid && !rdy;
            prev_rk = rk; prev_idx = rk_idx;
            step();
        end
        n_asserts++; if (hs != 3) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=3", hs); end
        n_asserts++; if (dn != 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", dn); end
        rk_ready = 1'b1;
    endtask

    task automatic test_boundaries();
        int hs, dn, last_idx;
        rk_ready = 1'b1;
        kick(128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 6'd0);
        n_asserts++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got=%b exp=1", done); end
        n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid got=%b exp=0", rk_valid); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got=%b exp=0", busy); end
        step();
        n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_once got=%b exp=0", done); end
        kick(128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 6'd63);
        hs = 0; dn = 0; last_idx = -1;
        for (int c = 0; c < 60; c++) begin
            if (rk_valid) begin hs++; last_idx = int'(rk_idx); end
            if (done) dn++;
            step();
        end
        n_asserts++; if (hs != 40) begin n_fail++; $display("FAIL clamp_handshakes got=%0d exp=40", hs); end
        n_asserts++; if (last_idx != 39) begin n_fail++; $display("FAIL clamp_last_idx got=%0d exp=39", last_idx); end
        n_asserts++; if (dn != 1) begin n_fail++; $display("FAIL clamp_done_count got=%0d exp=1", dn); end
    endtask

    task automatic test_abort();
        rk_ready = 1'b1;
        kick(128'h00000000_00000000_00000000_00001234, 6'd5);
        step(); step();
        n_asserts++; if (rk_idx !== 6'd2) begin n_fail++; $display("FAIL abort_pre_idx got=%0d exp=2", rk_idx); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got=%b exp=0", rk_valid); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        for (int c = 0; c < 3; c++) begin
            n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done cyc=%0d got=%b exp=0", c, done); end
            step();
        end
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy got=%b exp=0", busy); end
        n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL abort_start_valid got=%b exp=0", rk_valid); end
        step();
        n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_start_done got=%b exp=0", done); end
    endtask

    task automatic test_midreset();
        rk_ready = 1'b0;
        kick(128'h33333333_22222222_11111111_00000000, 6'd5);
        rk_ready = 1'b1;
        step();
        n_asserts++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_valid got=%b exp=1", rk_valid); end
        rstn = 1'b0;
        #1;
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got=%b exp=0", rk_valid); end
        n_asserts++; if (rk !== 64'h0) begin n_fail++; $display("FAIL mrst_rk got=%h exp=0", rk); end
        n_asserts++; if (rk_idx !== 6'd0) begin n_fail++; $display("FAIL mrst_idx got=%0d exp=0", rk_idx); end
        n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrst_done got=%b exp=0", done); end
        #2 rstn = 1'b1;
        step();
        n_asserts++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_post_valid got=%b exp=0", rk_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_boundaries();
        test_abort();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gift_key_sched.md
Name: gift_key_sched

Overview:
- Sequencer that generates the GIFT-128 round-key stream from a 128-bit master key.
- Holds the 4x32-bit key state and applies the GIFT key-update word function once per round, sharing one update unit across the round loop.
- Delivers one 64-bit round key per valid/ready handshake to the round datapath or a key cache.
- Sits beside the GIFT ISE unit as the hardware key-schedule path for the accelerated (non-ISE) configuration.

Parameters:
- MAX_ROUNDS, 40, upper bound on rounds per schedule; the nrounds input is clamped to this value.
- IDX_W, 6, width of the round-index and round-count fields; must satisfy 2^IDX_W > MAX_ROUNDS.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  request new schedule; accepted only when busy=0
- key  in  128  master key; K3=key[127:96], K2=key[95:64], K1=key[63:32], K0=key[31:0]; sampled on accepted start
- nrounds  in  IDX_W  number of round keys to emit; sampled on accepted start
- abort  in  1  cancel the running schedule
- busy  out  1  high from the cycle after accept until return to IDLE
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts the round key
- rk  out  64  round key {K2,K0} of the current state
- rk_idx  out  IDX_W  index of the round key presented, 0-based
- done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset values (async, rstn=0): state=IDLE, K3..K0=0, busy=0, rk_valid=0, rk=0, rk_idx=0, done=0, round counter=0.
- Key-update function ku(x):
  - ((x>>12)&0x0000000F) | ((x<<4)&0x0000FFF0) | ((x>>2)&0x3FFF0000) | ((x<<14)&0xC0000000).
- State update after each handshake: {K3,K2,K1,K0} <= {ku(K0), K3, K2, K1}.
- FSM: IDLE, EMIT, FIN.
- IDLE:
  - start=1: load K from key and n=min(nrounds,MAX_ROUNDS); rk_idx<=0.
  - If n=0, go to FIN. Otherwise go to EMIT with rk_valid<=1.
  - Latency from start to first rk_valid is 1 cycle.
- EMIT:
  - rk is a combinational function of the registered state; it is stable while rk_valid=1 and rk_ready=0.
  - Handshake (rk_valid&rk_ready): update K, increment rk_idx.
  - If rk_idx==n-1 at handshake: rk_valid<=0, go to FIN. Otherwise rk_valid stays 1, with the next key in the following cycle.
  - Sustained throughput: 1 key/cycle with rk_ready held high.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- start outside IDLE is ignored; there is no queueing.
- abort:
  - In EMIT or FIN: next state IDLE, rk_valid<=0, done not pulsed, K retained (not cleared).
  - abort and handshake in the same cycle: abort wins; the key counts as consumed but no update is required.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins, start is dropped.
- rk_idx wraps never: it is bounded by n-1 < 2^IDX_W.
- rstn asserted mid-schedule: immediate return to reset values. The consumer must discard any partial stream.

Optional Feature:
- Macro: GIFT_KEY_SCHED_RC_EN
- Defined:
  - Adds output rc [5:0], the GIFT round constant for rk_idx.
  - 6-bit LFSR, reset and load value 0.
  - Each emitted key uses rc_next = {rc[4:0], rc[5]^rc[4]^1'b1}, so round 0 has rc=0x01 and round 1 has rc=0x03.
  - The LFSR advances on handshake and reloads on accepted start.
- Undefined: no rc port and no LFSR logic; all other behaviour is identical.

Test Plan:
- Reset/idle: rstn low then high, no start -> busy=0, rk_valid=0, done=0, rk=0 for 10 cycles.
- Single round: key=0x00000000_00000000_00000000_00001234, nrounds=1, rk_ready=1 -> rk_valid one cycle after start with rk=0x00000000_00001234 and rk_idx=0; done pulses next cycle.
- Update chain: same key, nrounds=5, rk_ready=1 -> keys 0..3 all show rk={K2,K0} of the shifted words; key 4 has K0=ku(0x1234)=0x00002341, so rk[31:0]=0x00002341. Also check ku(0x00010000)=0x40000000.
- Backpressure: nrounds=3, rk_ready toggled 0/1 randomly -> rk/rk_idx stable while stalled; exactly 3 handshakes with rk_idx 0,1,2; one done pulse.
- Boundaries: nrounds=0 -> done pulse 1 cycle after start and no rk_valid. nrounds=63 with MAX_ROUNDS=40 -> exactly 40 handshakes.
- Abort/reset: abort after 2 handshakes -> rk_valid=0 next cycle, no done, busy=0. rstn pulsed mid-EMIT -> all outputs at reset values immediately. With GIFT_KEY_SCHED_RC_EN, rc is 0x01, 0x03, 0x07 on rounds 0-2.
